mul_div_unit: RTL and testbench

//  Iterative RV64M multiply/divide unit in the execute stage, directly downstream of

---
 rtl/mul_div_unit.sv | 180 ++++++++++++++++++
 tb/tb_mul_div_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative RV64M multiply/divide unit with start/busy/done handshake
//
// Purpose: shift-add multiplier and restoring divider, one bit per cycle,
//   operands latched at accept, result tagged with the destination register.
//   Optional macro MULDIV_DIV_EN enables the divider; without it, funct3[2]
//   ops finish after one cycle with result 0.
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset
//   start   in   request, accepted only when idle
//   funct3  in   [2:0] op select (MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU)
//   op_a    in   [XLEN-1:0] rs1 value
//   op_b    in   [XLEN-1:0] rs2 value
//   rd_in   in   [4:0] destination register
//   busy    out  high from accept through the done cycle
//   done    out  one-cycle pulse, result/rd_out valid
//   result  out  [XLEN-1:0] result, held until the next completion
//   rd_out  out  [4:0] rd captured at accept
module mul_div_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;      // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] prod_q, prod_d;      // {hi, lo}: product, or {remainder, quotient}
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_q, rd_d;
  logic [4:0]        rd_out_q, rd_out_d;

  // Operand signedness and magnitudes; MUL is treated as signed since its low half
  // is identical either way.
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  assign a_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
  assign b_signed = funct3[2] ? ~funct3[0] : ~funct3[1];
  assign a_neg    = a_signed & op_a[XLEN-1];
  assign b_neg    = b_signed & op_b[XLEN-1];
  assign a_mag    = a_neg ? -op_a : op_a;
  assign b_mag    = b_neg ? -op_b : op_b;

  // Special cases bypass the iteration and complete in a single cycle.
  logic            special;
  logic [XLEN-1:0] spec_res;
`ifdef MULDIV_DIV_EN
  localparam logic [XLEN-1:0] MIN_S = {1'b1, {(XLEN-1){1'b0}}};
  logic div_zero, div_ovf;
  assign div_zero = (op_b == '0);
  assign div_ovf  = ~funct3[0] && (op_a == MIN_S) && (op_b == '1);
  assign special  = funct3[2] && (div_zero || div_ovf);
  assign spec_res = div_zero ? (funct3[1] ? op_a : '1)
                             : (funct3[1] ? '0 : op_a);
`else
  assign special  = funct3[2];
  assign spec_res = '0;
`endif

  // Multiply step: conditionally add the multiplicand to the high half, shift right.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, prod_fix;
  logic [XLEN-1:0]   mul_res;
  assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, prod_q[XLEN-1:1]};
  assign prod_fix = neg_q ? -prod_q : prod_q;
  assign mul_res  = (f3_q == 3'b000) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];

`ifdef MULDIV_DIV_EN
  // Restoring divide step: shift in the next dividend bit, subtract if it fits.
  // Bit XLEN of the difference is set exactly when the trial subtraction underflows.
  logic [XLEN:0]     div_shift, div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [XLEN-1:0]   div_sel, div_res;
  assign div_shift = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], prod_q[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0],  prod_q[XLEN-2:0], 1'b1};
  assign div_sel   = f3_q[1] ? prod_q[2*XLEN-1:XLEN] : prod_q[XLEN-1:0];
  assign div_res   = neg_q ? -div_sel : div_sel;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      rd_q     <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      opnd_q   <= opnd_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      rd_out_q <= rd_out_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    opnd_d   = opnd_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    rd_d     = rd_q;
    rd_out_d = rd_out_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          f3_d  = funct3;
          rd_d  = rd_in;
          cnt_d = '0;
          if (special) begin
            result_d = spec_res;
            rd_out_d = rd_in;
            state_d  = S_DONE;
          end else begin
            // Remainder sign follows the dividend; everything else is the xor.
            neg_d   = (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
            opnd_d  = funct3[2] ? b_mag : a_mag;
            prod_d  = {{XLEN{1'b0}}, (funct3[2] ? a_mag : b_mag)};
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
`ifdef MULDIV_DIV_EN
        prod_d = f3_q[2] ? div_next : mul_next;
`else
        prod_d = mul_next;
`endif
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN - 1)) state_d = S_FIX;
      end
      S_FIX: begin
`ifdef MULDIV_DIV_EN
        result_d = f3_q[2] ? div_res : mul_res;
`else
        result_d = mul_res;
`endif
        rd_out_d = rd_q;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - scoreboard testbench for mul_div_unit
module tb_mul_div_unit;
  localparam int XLEN = 64;
  localparam int LAT  = XLEN + 2;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam logic [63:0] MIN_S = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [63:0] op_a = '0;
  logic [63:0] op_b = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, done;
  logic [63:0] result;
  logic [4:0]  rd_out;

  mul_div_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    int          acc;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;
  bit   b2b = 1'b0;
  int   last_done = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain wide arithmetic straight from the M-extension rules.
  function automatic logic [63:0] ref_model(input logic [2:0] f, input logic [63:0] a,
                                            input logic [63:0] b);
    logic        [127:0] p;
    logic signed [127:0] sp;
    logic signed [63:0]  sa, sbv;
    sa  = a;
    sbv = b;
    case (f)
      3'd0: return a * b;
      3'd1: begin sp = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); return sp[127:64]; end
      3'd2: begin p = {{64{a[63]}}, a} * {64'b0, b}; return p[127:64]; end
      3'd3: begin p = {64'b0, a} * {64'b0, b}; return p[127:64]; end
      default: begin
        if (!DIV_EN) return 64'd0;
        case (f)
          3'd4: begin
            if (b == 0) return '1;
            if (a == MIN_S && b == '1) return a;
            return sa / sbv;
          end
          3'd5: return (b == 0) ? '1 : a / b;
          3'd6: begin
            if (b == 0) return a;
            if (a == MIN_S && b == '1) return 64'd0;
            return sa % sbv;
          end
          default: return (b == 0) ? a : a % b;
        endcase
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
    if (!f[2]) return LAT;
    if (!DIV_EN) return 1;
    if (b == 0 || (!f[0] && a == MIN_S && b == '1)) return 1;
    return LAT;
  endfunction

  function automatic logic [63:0] pick_val();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0: v = 64'd0;
      1: v = '1;
      2: v = MIN_S;
      3: v = 64'($urandom_range(0, 100));
      4: begin v = 64'($urandom_range(1, 100)); v = -v; end
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // Monitor: every done pulse pops one expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", result, e.res);
        chk("rd_out", 64'(rd_out), 64'(e.rd));
        chk("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
        chk("busy_with_done", 64'(busy), 64'd1);
        if (b2b && last_done >= 0) chk("b2b_accept_gap", 64'(e.acc - last_done), 64'd2);
        last_done = cyc;
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=1 expected 0 within 200 cycles");
    end
  endtask

  task automatic issue(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] r, input logic [63:0] res, input int lat);
    exp_t e;
    wait_idle();
    funct3 = f; op_a = a; op_b = b; rd_in = r; start = 1'b1;
    e = '{res, r, cyc + 1, lat};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    funct3 = 3'($urandom); op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom};
    rd_in = 5'($urandom);
  endtask

  task automatic issue_rand();
    logic [2:0]  f;
    logic [63:0] a, b;
    f = 3'($urandom_range(0, 7));
    a = pick_val();
    b = pick_val();
    issue(f, a, b, 5'($urandom), ref_model(f, a, b), exp_lat(f, a, b));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_result", result, 64'd0);
    chk("reset_rd_out", 64'(rd_out), 64'd0);
    rst = 1'b0;

    // Directed cases with hand-computed expectations.
    issue(3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd9, 64'hFFFF_FFFF_FFFF_FFEB, LAT);
    issue(3'd3, '1, '1, 5'd17, 64'hFFFF_FFFF_FFFF_FFFE, LAT);
    issue(3'd1, '1, '1, 5'd3, 64'd0, LAT);
    issue(3'd4, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd1, DIV_EN ? 64'hFFFF_FFFF_FFFF_FFFA : 64'd0, DIV_EN ? LAT : 1);
    issue(3'd6, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd2, DIV_EN ? 64'hFFFF_FFFF_FFFF_FFFE : 64'd0, DIV_EN ? LAT : 1);
    issue(3'd5, 64'd100, 64'd7, 5'd4, DIV_EN ? 64'd14 : 64'd0, DIV_EN ? LAT : 1);
    issue(3'd7, 64'd100, 64'd7, 5'd5, DIV_EN ? 64'd2 : 64'd0, DIV_EN ? LAT : 1);
    issue(3'd4, 64'd123, 64'd0, 5'd6, DIV_EN ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0, 1);
    issue(3'd6, 64'h1234, 64'd0, 5'd7, DIV_EN ? 64'h1234 : 64'd0, 1);
    issue(3'd4, MIN_S, '1, 5'd8, DIV_EN ? MIN_S : 64'd0, 1);
    issue(3'd6, MIN_S, '1, 5'd10, 64'd0, 1);
    issue(3'd5, 64'd55, 64'd0, 5'd11, DIV_EN ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0, 1);
    issue(3'd7, 64'd55, 64'd0, 5'd12, DIV_EN ? 64'd55 : 64'd0, 1);

    // Randomized operations against the reference model.
    repeat (40) issue_rand();
    drain();

    // start held high: back-to-back MULs, inputs scrambled while busy.
    wait_idle();
    b2b = 1'b1;
    last_done = -1;
    funct3 = 3'd0;
    start = 1'b1;
    for (int i = 0; i < 200 || !busy; i++) begin
      if (!busy) begin
        exp_t e;
        e = '{ref_model(3'd0, op_a, op_b), rd_in, cyc + 1, LAT};
        exp_q.push_back(e);
      end else begin
        op_a = pick_val();
        op_b = pick_val();
        rd_in = 5'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    drain();
    b2b = 1'b0;

    // Reset in the middle of a multiply.
    issue(3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd9, 64'hFFFF_FFFF_FFFF_FFEB, LAT);
    drain();
    issue(3'd0, 64'd5, 64'd6, 5'd4, 64'd30, LAT);
    repeat (29) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midreset_busy", 64'(busy), 64'd0);
    chk("midreset_done", 64'(done), 64'd0);
    chk("midreset_result", result, 64'd0);
    chk("midreset_rd_out", 64'(rd_out), 64'd0);
    exp_q.delete();
    n = done_seen;
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("no_done_after_reset", 64'(done_seen), 64'(n));

    issue_rand();
    issue_rand();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
